stopwatch_ctrl_n: RTL and testbench

Parametrised control core for the FPGA stopwatch/timer, replacing the fixed 4-digit up/down state machine. It owns the mode FSM, the N-digit BCD count value, the down-mode preset and its digit-edit cursor, and the expiry/wrap flags. It sits between the board I/O (raw buttons, mode switch, prescaler tick) and the 7-segment display driver.

---
 rtl/stopwatch_ctrl_n.sv | 221 ++++++++++++++++++++++
 tb/tb_stopwatch_ctrl_n.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl_n.sv
// Stopwatch/timer control core: button/mode conditioning, mode FSM, N-digit BCD
// up/down counter, down-mode preset editor with digit cursor, expiry and wrap pulses.
module stopwatch_ctrl_n #(
  parameter int DIGITS = 4,
  parameter int CW     = $clog2(DIGITS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [4:0]          btn_in,
  input  logic                mode,
  input  logic                tick,
  output logic [2:0]          state,
  output logic [4*DIGITS-1:0] value,
  output logic [CW-1:0]       cursor,
  output logic                done,
  output logic                wrap
);

  localparam int VW = 4 * DIGITS;

  typedef enum logic [2:0] {
    UP_WAIT = 3'd0,
    UP_RUN  = 3'd1,
    DN_WAIT = 3'd2,
    DN_RUN  = 3'd3,
    EXPIRED = 3'd4
  } state_t;

  function automatic logic [VW-1:0] bcd_inc(input logic [VW-1:0] v);
    logic [VW-1:0] r;
    logic          c;
    r = v;
    c = 1'b1;
    for (int j = 0; j < DIGITS; j++) begin
      if (c) begin
        if (v[4*j +: 4] == 4'd9) r[4*j +: 4] = 4'd0;
        else begin
          r[4*j +: 4] = v[4*j +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [VW-1:0] bcd_dec(input logic [VW-1:0] v);
    logic [VW-1:0] r;
    logic          b;
    r = v;
    b = 1'b1;
    for (int j = 0; j < DIGITS; j++) begin
      if (b) begin
        if (v[4*j +: 4] == 4'd0) r[4*j +: 4] = 4'd9;
        else begin
          r[4*j +: 4] = v[4*j +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [3:0] digit_step(input logic [3:0] d, input logic up);
    if (up) return (d == 4'd9) ? 4'd0 : d + 4'd1;
    else    return (d == 4'd0) ? 4'd9 : d - 4'd1;
  endfunction

  logic [4:0]    btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d, btn_h_q, btn_h_d, btn_ev_q, btn_ev_d;
  logic          mode_s1_q, mode_s1_d, mode_s2_q, mode_s2_d, mode_h_q, mode_h_d;
  logic          mode_ev_q, mode_ev_d;
  state_t        state_q, state_d;
  logic [VW-1:0] value_q, value_d, preset_q, preset_d;
  logic [CW-1:0] cursor_q, cursor_d;
  logic          paused_q, paused_d, done_q, done_d, wrap_q, wrap_d;

  // Input conditioning: sync, history, then a registered event pulse
  always_comb begin
    btn_s1_d  = btn_in;
    btn_s2_d  = btn_s1_q;
    btn_h_d   = btn_s2_q;
    btn_ev_d  = btn_s2_q & ~btn_h_q;
    mode_s1_d = mode;
    mode_s2_d = mode_s1_q;
    mode_h_d  = mode_s2_q;
    mode_ev_d = mode_s2_q ^ mode_h_q;
  end

  // Next state and datapath
  always_comb begin
    state_d  = state_q;
    value_d  = value_q;
    preset_d = preset_q;
    cursor_d = cursor_q;
    paused_d = paused_q;
    done_d   = 1'b0;
    wrap_d   = 1'b0;
    if (mode_ev_q) begin
      cursor_d = '0;
      paused_d = 1'b0;
      if (mode_h_q) begin
        state_d = UP_WAIT;
        value_d = '0;
      end else begin
        state_d = DN_WAIT;
      end
    end else if (|btn_ev_q) begin
      unique case (state_q)
        UP_WAIT: begin
          if (btn_ev_q[1]) value_d = '0;
          else if (btn_ev_q[0]) begin
            state_d  = UP_RUN;
            cursor_d = '0;
          end
        end
        UP_RUN: begin
          if (btn_ev_q[1]) begin
            state_d = UP_WAIT;
            value_d = '0;
          end else if (btn_ev_q[0]) state_d = UP_WAIT;
        end
        DN_WAIT: begin
          if (btn_ev_q[1]) begin
            preset_d = '0;
            cursor_d = '0;
            paused_d = 1'b0;
          end else if (btn_ev_q[0]) begin
            if (preset_q != '0) begin
              state_d  = DN_RUN;
              cursor_d = '0;
              paused_d = 1'b0;
            end
          end else if (btn_ev_q[2]) begin
            cursor_d = (cursor_q == CW'(DIGITS - 1)) ? '0 : cursor_q + CW'(1);
            paused_d = 1'b0;
          end else if (btn_ev_q[3] || btn_ev_q[4]) begin
            for (int i = 0; i < DIGITS; i++)
              if (cursor_q == CW'(i))
                preset_d[4*(DIGITS-i)-1 -: 4] = digit_step(preset_q[4*(DIGITS-i)-1 -: 4], btn_ev_q[3]);
            paused_d = 1'b0;
          end
        end
        DN_RUN: begin
          if (btn_ev_q[1]) begin
            state_d  = DN_WAIT;
            paused_d = 1'b0;
          end else if (btn_ev_q[0]) begin
            state_d  = DN_WAIT;
            paused_d = 1'b1;
          end
        end
        EXPIRED: begin
          if (btn_ev_q[1] || btn_ev_q[0]) begin
            state_d  = DN_WAIT;
            paused_d = 1'b0;
          end
        end
        default: state_d = UP_WAIT;
      endcase
    end else if (tick) begin
      if (state_q == UP_RUN) begin
        value_d = bcd_inc(value_q);
        wrap_d  = (value_d == '0);
      end else if (state_q == DN_RUN) begin
        value_d = bcd_dec(value_q);
        if (value_d == '0) begin
          state_d = EXPIRED;
          done_d  = 1'b1;
        end
      end
    end
    // A paused countdown keeps its held value; otherwise DN_WAIT tracks the preset
    if (state_d == DN_WAIT && !paused_d) value_d = preset_d;
    if (state_d == EXPIRED) value_d = '0;
  end

  // Chains reset high so a level held through reset never looks like a fresh edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_s1_q  <= '1;
      btn_s2_q  <= '1;
      btn_h_q   <= '1;
      btn_ev_q  <= '0;
      mode_s1_q <= 1'b1;
      mode_s2_q <= 1'b1;
      mode_h_q  <= 1'b1;
      mode_ev_q <= 1'b0;
      state_q   <= UP_WAIT;
      value_q   <= '0;
      preset_q  <= '0;
      cursor_q  <= '0;
      paused_q  <= 1'b0;
      done_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      btn_s1_q  <= btn_s1_d;
      btn_s2_q  <= btn_s2_d;
      btn_h_q   <= btn_h_d;
      btn_ev_q  <= btn_ev_d;
      mode_s1_q <= mode_s1_d;
      mode_s2_q <= mode_s2_d;
      mode_h_q  <= mode_h_d;
      mode_ev_q <= mode_ev_d;
      state_q   <= state_d;
      value_q   <= value_d;
      preset_q  <= preset_d;
      cursor_q  <= cursor_d;
      paused_q  <= paused_d;
      done_q    <= done_d;
      wrap_q    <= wrap_d;
    end
  end

  always_comb begin
    state  = state_q;
    value  = value_q;
    cursor = cursor_q;
    done   = done_q;
    wrap   = wrap_q;
  end

endmodule

// File: tb/tb_stopwatch_ctrl_n.sv
// Directed bench for stopwatch_ctrl_n: a 4-digit and a 6-digit instance share one
// stimulus stream; expected values are hand-computed per instance.
module tb_stopwatch_ctrl_n;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  btn_in;
  logic        mode;
  logic        tick;
  logic [2:0]  state4, state6;
  logic [15:0] value4;
  logic [23:0] value6;
  logic [1:0]  cursor4;
  logic [2:0]  cursor6;
  logic        done4, wrap4, done6, wrap6;

  localparam int START = 0, CLR = 1, SEL = 2, INC = 3, DEC = 4;

  always #5 clk = ~clk;

  stopwatch_ctrl_n #(.DIGITS(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .btn_in(btn_in), .mode(mode), .tick(tick),
    .state(state4), .value(value4), .cursor(cursor4), .done(done4), .wrap(wrap4)
  );

  stopwatch_ctrl_n #(.DIGITS(6)) dut6 (
    .clk(clk), .reset_n(reset_n), .btn_in(btn_in), .mode(mode), .tick(tick),
    .state(state6), .value(value6), .cursor(cursor6), .done(done6), .wrap(wrap6)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int b);
    btn_in[b] = 1'b1;
    step(4);
    btn_in[b] = 1'b0;
    step(4);
  endtask

  task automatic ticks(input int n);
    tick = 1'b1;
    step(n);
    tick = 1'b0;
  endtask

  task automatic set_mode(input logic m);
    mode = m;
    step(4);
  endtask

  initial begin
    reset_n = 1'b0;
    btn_in  = '0;
    mode    = 1'b1;
    tick    = 1'b0;
    step(3);
    chk("rst_state", state4, 0);
    chk("rst_value", value4, 0);
    chk("rst_cursor", cursor4, 0);
    chk("rst_done", done4, 0);
    chk("rst_wrap", wrap4, 0);
    reset_n = 1'b1;
    step(5);
    chk("post_rst_state", state4, 0);

    // Up count and pause
    press(START);
    chk("up_run4", state4, 1);
    chk("up_run6", state6, 1);
    ticks(10);
    chk("up10_v4", value4, 16'h0010);
    chk("up10_v6", value6, 24'h000010);
    chk("up10_st", state4, 1);
    press(START);
    chk("up_stop_st", state4, 0);
    chk("up_stop_v", value4, 16'h0010);

    // Tick in the event cycle is ignored; ticks in UP_WAIT are ignored
    press(START);
    ticks(5);
    chk("up15_v", value4, 16'h0015);
    btn_in[START] = 1'b1;
    step(3);
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    btn_in[START] = 1'b0;
    chk("evt_tick_st", state4, 0);
    chk("evt_tick_v", value4, 16'h0015);
    step(4);
    ticks(1);
    chk("wait_tick_v", value4, 16'h0015);

    // Clear beats start
    press(START);
    ticks(2);
    chk("up17_v", value4, 16'h0017);
    btn_in[START] = 1'b1;
    btn_in[CLR]   = 1'b1;
    step(3);
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    btn_in = '0;
    step(4);
    chk("prio_st", state4, 0);
    chk("prio_v", value4, 0);

    // Wrap from all nines
    press(START);
    ticks(9999);
    chk("up9999_v4", value4, 16'h9999);
    chk("up9999_v6", value6, 24'h009999);
    ticks(1);
    chk("wrap_v4", value4, 0);
    chk("wrap_pulse4", wrap4, 1);
    chk("wrap_st4", state4, 1);
    chk("nowrap_v6", value6, 24'h010000);
    chk("nowrap6", wrap6, 0);
    step(1);
    chk("wrap_clr4", wrap4, 0);
    press(START);
    chk("up_stop2", state4, 0);

    // Down mode editing
    set_mode(1'b0);
    chk("dn_st", state4, 2);
    chk("dn_v", value4, 0);
    chk("dn_cur", cursor4, 0);
    press(SEL);
    chk("sel_cur", cursor4, 1);
    press(INC); press(INC); press(INC); press(DEC);
    chk("edit_v4", value4, 16'h0200);
    chk("edit_v6", value6, 24'h020000);
    chk("edit_cur", cursor4, 1);
    press(DEC); press(DEC); press(DEC);
    chk("dec_wrap_v4", value4, 16'h0900);
    chk("dec_wrap_v6", value6, 24'h090000);

    // Clear, then start with zero preset is ignored
    press(CLR);
    chk("dn_clr_v", value4, 0);
    chk("dn_clr_cur", cursor4, 0);
    press(START);
    chk("zero_start4", state4, 2);
    chk("zero_start6", state6, 2);

    // Preset 3, cursor wrap, run to expiry
    press(SEL); press(SEL); press(SEL);
    chk("cur3", cursor4, 3);
    press(INC); press(INC); press(INC);
    chk("pre3_v4", value4, 16'h0003);
    chk("pre3_v6", value6, 24'h000300);
    press(SEL);
    chk("cur_wrap4", cursor4, 0);
    chk("cur_nowrap6", cursor6, 4);
    press(START);
    chk("dn_run4", state4, 3);
    chk("dn_run_cur4", cursor4, 0);
    chk("dn_run6", state6, 3);
    chk("dn_run_cur6", cursor6, 0);
    ticks(1);
    chk("dn_v2", value4, 16'h0002);
    ticks(1);
    chk("dn_v1", value4, 16'h0001);
    ticks(1);
    chk("dn_v0", value4, 0);
    chk("exp_st", state4, 4);
    chk("done_pulse", done4, 1);
    chk("dn6_297", value6, 24'h000297);
    chk("done6_low", done6, 0);
    step(1);
    chk("done_clr", done4, 0);
    chk("exp_hold", state4, 4);
    ticks(1);
    chk("exp_tick_v", value4, 0);
    chk("exp_tick_st", state4, 4);
    chk("dn6_296", value6, 24'h000296);
    press(START);
    chk("exp_start_st", state4, 2);
    chk("exp_start_v", value4, 16'h0003);
    chk("pause6_st", state6, 2);
    chk("pause6_v", value6, 24'h000296);

    // Pause and resume keep the held count
    press(START);
    chk("resume_st4", state4, 3);
    chk("resume_st6", state6, 3);
    ticks(1);
    chk("res_v4", value4, 16'h0002);
    chk("res_v6", value6, 24'h000295);
    press(START);
    chk("pause_st", state4, 2);
    chk("pause_v", value4, 16'h0002);
    press(START);
    chk("resume2_st", state4, 3);
    ticks(1);
    chk("res2_v4", value4, 16'h0001);
    chk("res2_v6", value6, 24'h000294);
    press(CLR);
    chk("dn_clr_st", state4, 2);
    chk("dn_clr_reload4", value4, 16'h0003);
    chk("dn_clr_reload6", value6, 24'h000300);
    press(START);
    chk("run3_st", state4, 3);

    // Mode flip mid-run and back
    set_mode(1'b1);
    chk("flip_st4", state4, 0);
    chk("flip_v4", value4, 0);
    chk("flip_cur4", cursor4, 0);
    chk("flip_st6", state6, 0);
    chk("flip_v6", value6, 0);
    set_mode(1'b0);
    chk("back_st4", state4, 2);
    chk("back_v4", value4, 16'h0003);
    chk("back_v6", value6, 24'h000300);

    // Reset mid-run with start held
    btn_in[START] = 1'b1;
    step(4);
    chk("held_run", state4, 3);
    reset_n = 1'b0;
    mode    = 1'b1;
    step(2);
    chk("midrst_st", state4, 0);
    chk("midrst_v", value4, 0);
    reset_n = 1'b1;
    step(6);
    chk("held_no_retrig", state4, 0);
    btn_in = '0;
    step(4);
    press(START);
    chk("after_rst_start", state4, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
